// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues in-order word reads to instruction memory
// and buffers PC-tagged instructions for the decoder, squashing wrong-path responses on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic        fetch_fault
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     r_pc;
  logic [31:0]     r_resp_pc;
  logic [CntW-1:0] r_out;
  logic [CntW-1:0] r_drop;
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic            r_fault;
  logic [31:0]     r_mem_data [DEPTH];
  logic [31:0]     r_mem_pc   [DEPTH];

  logic [CntW+1:0] w_inflight;
  logic            w_fire;
  logic            w_push;
  logic            w_resp_drop;
  logic            w_empty;
  logic            w_pop;

  // Outstanding requests, buffered entries and pending drops share one budget of DEPTH slots,
  // so every accepted response is guaranteed a FIFO slot.
  assign w_inflight  = {2'b00, r_out} + {2'b00, r_count} + {2'b00, r_drop};

  assign imem_req_valid = !rst && !r_fault && !redirect_valid &&
                          (w_inflight < (CntW+2)'(DEPTH));
  assign imem_addr      = r_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  assign w_resp_drop = imem_resp_valid && (r_drop != '0);
  assign w_push      = !rst && imem_resp_valid && (r_drop == '0) && !redirect_valid;

  assign w_empty    = (r_count == '0);
  assign inst_valid = !w_empty && !redirect_valid;
  assign w_pop      = inst_valid && inst_ready;

  assign inst        = w_empty ? 32'h0 : r_mem_data[r_rd_ptr];
  assign inst_pc     = w_empty ? 32'h0 : r_mem_pc[r_rd_ptr];
  assign opcode      = inst[6:0];
  assign fetch_fault = r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_out     <= '0;
      r_drop    <= '0;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_fault   <= 1'b0;
    end else if (redirect_valid) begin
      r_pc      <= redirect_pc;
      r_resp_pc <= redirect_pc;
      r_count   <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      // Everything still in flight is wrong-path; a response landing now is one of them.
      r_drop    <= r_drop + r_out - CntW'(imem_resp_valid);
      r_out     <= '0;
      r_fault   <= |redirect_pc[1:0];
    end else begin
      if (w_fire) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_resp_drop) begin
        r_drop <= r_drop - CntW'(1);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      r_out   <= r_out + CntW'(w_fire) - CntW'(w_push);
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= imem_resp_data;
      r_mem_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

`ifndef SYNTHESIS
  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    w_push |-> (r_count < CntW'(DEPTH)));
  a_resp_expected : assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> ((r_out + r_drop) != '0));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based memory and delivery model, directed
// scenarios pinned with literal expectations, then a long randomized run.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        fetch_fault;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .opcode          (opcode),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          cyc;
  } pop_t;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          t0       = 0;
  int          ready_mode = 0;  // 0: always ready, 1: never ready, 2: random
  int          lat_min  = 1;
  int          lat_max  = 1;

  mreq_t       mem_q[$];
  pop_t        pop_log[$];
  int          m_buf    = 0;
  int          m_epoch  = 0;
  logic [31:0] m_issue  = RESET_PC;
  logic [31:0] m_deliver = RESET_PC;
  logic        m_fault  = 1'b0;
  logic        rst_seen = 1'b0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Memory: in-order responses, one per cycle, each no earlier than its due cycle.
  always begin
    @(posedge clk);
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memfn(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    case (ready_mode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = 1'b0;
      default: imem_req_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Compare process: checks outputs mid-cycle, then advances the model across the next edge.
  always @(negedge clk) begin
    logic        exp_rv;
    logic        exp_fire;
    logic        exp_pop;
    logic [31:0] hd;
    mreq_t       e;
    int          lat;
    int          due;
    if (rst) begin
      chk("req_valid_in_rst", {31'b0, imem_req_valid}, 32'd0);
      mem_q.delete();
      m_buf     = 0;
      m_issue   = RESET_PC;
      m_deliver = RESET_PC;
      m_fault   = 1'b0;
      m_epoch++;
      rst_seen  = 1'b1;
    end else begin
      if (rst_seen) begin
        t0       = cyc;
        rst_seen = 1'b0;
      end
      exp_rv  = !m_fault && !redirect_valid && (mem_q.size() + m_buf < DEPTH);
      exp_pop = (m_buf > 0) && !redirect_valid && inst_ready;
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, (m_buf > 0) && !redirect_valid});
      if (exp_rv) chk("imem_addr", imem_addr, m_issue);
      if (m_buf > 0) begin
        hd = memfn(m_deliver);
        chk("inst_pc", inst_pc, m_deliver);
        chk("inst", inst, hd);
        chk("opcode", {25'b0, opcode}, {25'b0, hd[6:0]});
      end
      if (inst_valid && inst_ready) pop_log.push_back('{pc: inst_pc, data: inst, cyc: cyc});
      if (redirect_valid) begin
        m_epoch++;
        m_buf     = 0;
        m_issue   = redirect_pc;
        m_deliver = redirect_pc;
        m_fault   = |redirect_pc[1:0];
      end else begin
        exp_fire = exp_rv && imem_req_ready;
        if (exp_fire) begin
          lat = $urandom_range(lat_min, lat_max);
          due = cyc + lat;
          if (mem_q.size() > 0 && mem_q[$].due > due) due = mem_q[$].due;
          mem_q.push_back('{addr: m_issue, epoch: m_epoch, due: due});
          m_issue = m_issue + 32'd4;
        end
        if (exp_pop) begin
          m_buf--;
          m_deliver = m_deliver + 32'd4;
        end
      end
      if (imem_resp_valid && mem_q.size() > 0) begin
        e = mem_q.pop_front();
        if (e.epoch == m_epoch) m_buf++;
      end
    end
    cyc++;
  end

  initial begin
    int          n0;
    int          k;
    logic [31:0] a0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;

    // Reset state and 1-cycle streaming.
    cyc_wait(2);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    pop_log.delete();
    cyc_wait(1);
    rst = 1'b0;
    cyc_wait(12);
    chk("p1_pops", {31'b0, pop_log.size() >= 3}, 32'd1);
    if (pop_log.size() >= 3) begin
      chk("p1_pc0", pop_log[0].pc, 32'h0);
      chk("p1_cyc0", pop_log[0].cyc, t0 + 2);
      chk("p1_pc1", pop_log[1].pc, 32'h4);
      chk("p1_cyc1", pop_log[1].cyc, t0 + 3);
      chk("p1_pc2", pop_log[2].pc, 32'h8);
      chk("p1_cyc2", pop_log[2].cyc, t0 + 4);
    end

    // Backpressure fills the buffer and stops issue.
    inst_ready = 1'b0;
    cyc_wait(10);
    @(negedge clk);
    chk("p2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("p2_inst_valid", {31'b0, inst_valid}, 32'd1);
    n0 = pop_log.size();
    cyc_wait(1);
    inst_ready = 1'b1;
    cyc_wait(8);
    chk("p2_pops", {31'b0, pop_log.size() >= n0 + 4}, 32'd1);
    if (pop_log.size() >= n0 + 4) begin
      chk("p2_burst_cycles", pop_log[n0+3].cyc - pop_log[n0].cyc, 32'd3);
      chk("p2_burst_pcs", pop_log[n0+3].pc - pop_log[n0].pc, 32'd12);
    end

    // Long-latency memory, redirect with requests in flight.
    lat_min = 3;
    lat_max = 3;
    cyc_wait(8);
    k = 0;
    while (mem_q.size() < 3 && k < 50) begin
      cyc_wait(1);
      k++;
    end
    chk("p3_inflight_wait", {31'b0, k < 50}, 32'd1);
    n0 = pop_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cyc_wait(1);
    redirect_valid = 1'b0;
    cyc_wait(15);
    chk("p3_pops", {31'b0, pop_log.size() > n0}, 32'd1);
    if (pop_log.size() > n0) begin
      chk("p3_first_pc", pop_log[n0].pc, 32'h100);
      chk("p3_first_data", pop_log[n0].data, memfn(32'h100));
    end

    // Redirect coinciding with a response and a would-be pop.
    lat_min = 1;
    lat_max = 1;
    cyc_wait(6);
    k = 0;
    while (!(imem_resp_valid && inst_valid) && k < 50) begin
      cyc_wait(1);
      k++;
    end
    chk("p4_align_wait", {31'b0, k < 50}, 32'd1);
    n0 = pop_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    cyc_wait(1);
    redirect_valid = 1'b0;
    cyc_wait(8);
    if (pop_log.size() > n0) chk("p4_first_pc", pop_log[n0].pc, 32'h300);
    else chk("p4_pops", 32'd0, 32'd1);

    // Misaligned redirect faults, aligned one recovers.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    cyc_wait(1);
    redirect_valid = 1'b0;
    cyc_wait(4);
    @(negedge clk);
    chk("p5_fault_set", {31'b0, fetch_fault}, 32'd1);
    chk("p5_no_req", {31'b0, imem_req_valid}, 32'd0);
    cyc_wait(1);
    n0 = pop_log.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc_wait(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("p5_fault_clr", {31'b0, fetch_fault}, 32'd0);
    cyc_wait(8);
    if (pop_log.size() > n0) chk("p5_first_pc", pop_log[n0].pc, 32'h200);
    else chk("p5_pops", 32'd0, 32'd1);

    // Memory stall, then reset in the middle of it.
    ready_mode = 1;
    cyc_wait(2);
    @(negedge clk);
    a0 = imem_addr;
    cyc_wait(5);
    @(negedge clk);
    chk("p6_addr_stable", imem_addr, a0);
    chk("p6_req_held", {31'b0, imem_req_valid}, 32'd1);
    cyc_wait(1);
    rst = 1'b1;
    cyc_wait(1);
    rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    chk("p6_rst_addr", imem_addr, RESET_PC);
    chk("p6_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("p6_rst_fault", {31'b0, fetch_fault}, 32'd0);
    cyc_wait(4);

    // Randomized traffic.
    ready_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        lat_min = 1;
        lat_max = $urandom_range(1, 4);
      end
      inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 999) < 3) begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
      end else begin
        rst            = 1'b0;
        redirect_valid = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 19) == 0) redirect_pc = 32'hFFFF_FFF0;
        else redirect_pc = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 4) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      end
      cyc_wait(1);
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    cyc_wait(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- RV32I fetch stage directly upstream of the opcode decoder.
- Owns the PC and issues word reads to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions, tagged with their PCs, in a small FIFO.
- Presents them to decode with a valid/ready handshake; `opcode` is driven straight to the decoder.
- Handles redirects from branch/jump resolution, discarding wrong-path responses still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- DEPTH, 4, instruction FIFO entries; also the cap on outstanding requests plus buffered entries (power of two, ≥2).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  32  fetch address (current PC).
- imem_resp_valid  in  1  response data valid (in order; ≥1 cycle after acceptance).
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes head this cycle.
- inst  out  32  head instruction word.
- inst_pc  out  32  PC of head instruction.
- opcode  out  7  inst[6:0], feeds decoder.
- fetch_fault  out  1  sticky misaligned-redirect fault.

Behaviour:
- Reset (sync, priority over all):
  - pc = resp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; drop_cnt = 0; fetch_fault = 0.
  - All outputs 0 in the cycle after rst is sampled high, except imem_addr = RESET_PC.
  - Reset mid-operation discards the buffer and all in-flight accounting. The memory must not return responses for pre-reset requests.
- Request issue:
  - imem_req_valid = !fetch_fault && !redirect_valid && (outstanding + count + drop_cnt < DEPTH), all terms registered.
  - imem_addr = pc.
  - Fire = valid && ready: pc += 4 (wraps modulo 2^32), outstanding++.
  - While valid && !ready, addr stays stable.
- Response, per imem_resp_valid:
  - If drop_cnt > 0: drop_cnt--, data discarded.
  - Else: push {resp_pc, data}, resp_pc += 4, outstanding--.
  - Space is guaranteed by the issue rule; push onto a full FIFO is an assertion failure.
  - A response with outstanding + drop_cnt == 0 is an assertion failure.
- Output side:
  - inst_valid = !empty && !redirect_valid.
  - inst/inst_pc/opcode = head entry, registered storage, no combinational path from the imem inputs.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle keep count unchanged.
  - Outputs hold while valid && !ready.
- Latency: request accepted at cycle N with response at N+1 → inst_valid at N+2. With 1-cycle memory and DEPTH = 4, sustained throughput is 1 instr/cycle.
- Redirect (redirect_valid = 1, highest priority after rst):
  - FIFO flushed; no pop occurs this cycle.
  - pc = resp_pc = redirect_pc.
  - drop_cnt = drop_cnt + outstanding − (same-cycle response ? 1 : 0); outstanding = 0.
  - A same-cycle response is always discarded.
  - No request issued this cycle.
- Misaligned redirect (redirect_pc[1:0] ≠ 0): fetch_fault = 1; pc still loaded; issue blocked.
  - An aligned redirect clears fetch_fault.
  - Drops continue while faulted.
- Back-to-back redirects: each applies in full; the last one wins.

Test Plan:
- Reset then 1-cycle memory, inst_ready = 1 → imem_addr 0,4,8,… accepted every cycle; inst_pc 0,4,8 on consecutive cycles from cycle 2; opcode = inst[6:0].
- Hold inst_ready = 0 for 10 cycles → exactly 4 entries buffered, imem_req_valid = 0. Release → PCs 0..C delivered in order, none lost or duplicated.
- 3-cycle memory latency with 3 requests in flight, redirect_pc = 0x100 → 3 stale responses dropped. First delivered inst_pc = 0x100 with data from address 0x100.
- Redirect coinciding with imem_resp_valid and inst_ready → that response dropped, no pop counted, next inst_pc = redirect_pc.
- Redirect to 0x102 → fetch_fault = 1, no requests. Then redirect to 0x200 → fault clears, fetch resumes at 0x200.
- imem_req_ready = 0 for 5 cycles → imem_addr stable, pc unchanged. Assert rst mid-stall → next-cycle state matches fresh reset.
